uart_tx_frame_gen: RTL and testbench
====================================

Name: uart_tx_frame_gen

Overview:
Parametrised UART frame transmitter for the system's UART clock domain. Buffers parallel words in an internal FIFO and serialises each one as a UART frame: start bit, data LSB-first, optional even/odd parity, then 1 or 2 stop bits, at a fixed number of clocks per bit. It generalises the single-byte, fixed-format TX path to configurable data width, buffer depth, stop-bit count and back-to-back streaming. It is also used on-chip as a stimulus source that drives RX_IN of the system top.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9)
DEPTH, 4, FIFO entries; power of 2, at least 2
CLKS_PER_BIT, 8, CLK cycles per serial bit (at least 2)
STOP_BITS, 1, number of stop bits (1 or 2)
GAP_BITS, 2, idle bit-times inserted between frames (used only with UART_TX_FRAME_GAP_EN)

Ports:
CLK  in  1  clock (UART clock domain)
RST  in  1  synchronous, active-low reset
DIN_DATA  in  DATA_WIDTH  word to transmit
DIN_VLD  in  1  write request
DIN_RDY  out  1  FIFO not full; a write is accepted when DIN_VLD and DIN_RDY are both high at a CLK edge
PAR_EN  in  1  parity enable, sampled at frame start
PAR_TYP  in  1  parity type, 0 = even, 1 = odd, sampled at frame start
TX_OUT  out  1  serial line, idles high
BUSY  out  1  frame in progress
FIFO_CNT  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-low: RST=0 sampled at a CLK edge resets the block. Asynchronous assertion of RST has no effect.
- Reset values: TX_OUT=1, BUSY=0, FIFO_CNT=0, FSM=IDLE, FIFO pointers=0. DIN_RDY=0 while RST=0.
- DIN_RDY: DIN_RDY = (FIFO_CNT != DEPTH) when out of reset. It is combinational from registered count only.
- FIFO write/pop: a write while full is ignored. A push and a pop in the same cycle leave FIFO_CNT unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP, plus GAP (macro only).
- Bit timing: a bit counter counts 0..CLKS_PER_BIT-1. Every serial bit is held for exactly CLKS_PER_BIT cycles.
- IDLE: TX_OUT=1, BUSY=0. If FIFO_CNT != 0 at an edge:
  - pop the head word into the shift register;
  - latch PAR_EN and PAR_TYP;
  - compute parity: XOR of the data when even, its inverse when odd;
  - go to START, with TX_OUT<=0 and BUSY<=1 at that same edge.
- First-bit latency: a write accepted into an empty FIFO at edge N gives the start bit on TX_OUT from edge N+1.
- START: TX_OUT=0 for one bit, then DATA.
- DATA: shifts out DATA_WIDTH bits LSB-first, one per bit period. Then PARITY if the latched PAR_EN=1, else STOP.
- PARITY: TX_OUT=parity bit for one bit period.
- STOP: TX_OUT=1 for STOP_BITS bit periods. At the last cycle of the final stop bit:
  - if FIFO is non-empty, pop immediately and enter START. Frames are back-to-back with zero extra idle cycles.
  - else enter IDLE and drop BUSY.
- Frame length: exactly (1 + DATA_WIDTH + PAR_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Input changes mid-frame: PAR_EN and PAR_TYP changes mid-frame do not affect the current frame.
- Writes during transmission: writes accepted while a frame is in progress are queued normally.
- Reset mid-frame: at the reset edge, TX_OUT returns to 1 and the FIFO is flushed. The partial frame is abandoned.

Optional Feature:
UART_TX_FRAME_GAP_EN:
- Defined: after the stop bits, the FSM enters GAP, holding TX_OUT=1 for GAP_BITS*CLKS_PER_BIT cycles with BUSY=1. It then proceeds to START if the FIFO is non-empty, else to IDLE.
- Undefined: the GAP state and its counter are absent, and frames are back-to-back as above.

Test Plan:
1. Single word, parity on: reset, write 0xAA with PAR_EN=1, PAR_TYP=0 (CLKS_PER_BIT=8) -> start bit one cycle after the write; TX_OUT bits 0,0,1,0,1,0,1,0,1, parity 0, stop 1, each held 8 cycles; BUSY high for 88 cycles.
2. Odd parity: write 0x08 with PAR_EN=1, PAR_TYP=1 -> parity bit 0; with PAR_TYP=0 the parity bit is 1.
3. Parity off: write 0x0F with PAR_EN=0 -> frame of 80 cycles with no parity bit; bits 1,1,1,1,0,0,0,0 LSB-first.
4. Back-to-back and full: write 0x0A, 0x0F, 0xBB, 0xCC, 0xDD, 0xEE on consecutive cycles -> first five accepted; DIN_RDY low on the 6th until the first frame's final stop cycle; six frames contiguous with no idle cycle; FIFO_CNT peaks at 4.
5. Reset mid-frame: assert RST=0 for one edge during the DATA bits -> TX_OUT=1, BUSY=0, FIFO_CNT=0 after that edge; no further frame starts.
6. Frame gap (UART_TX_FRAME_GAP_EN, GAP_BITS=2): write two words -> 16 idle-high cycles between the stop bit and the next start bit.

Source files
------------

// File: rtl/uart_tx_frame_gen_if.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_gen_if
// Write-side handshake bundle for the UART frame transmitter.
//   DIN_DATA  word to transmit           (master -> slave)
//   DIN_VLD   write request              (master -> slave)
//   DIN_RDY   FIFO can accept a word     (slave  -> master)
// A word transfers on a CLK edge where DIN_VLD and DIN_RDY are both high.
// ---------------------------------------------------------------------------
interface uart_tx_frame_gen_if #(
   parameter int unsigned DATA_WIDTH = 8
);

   logic [DATA_WIDTH-1:0] DIN_DATA;
   logic                  DIN_VLD;
   logic                  DIN_RDY;

   modport master (
      output DIN_DATA,
      output DIN_VLD,
      input  DIN_RDY
   );

   modport slave (
      input  DIN_DATA,
      input  DIN_VLD,
      output DIN_RDY
   );

endinterface

// File: rtl/uart_tx_frame_gen.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_gen
// Buffers parallel words in a small FIFO and serialises each as a UART frame:
// start bit, DATA_WIDTH data bits LSB-first, optional even/odd parity, then
// STOP_BITS stop bits. Every bit lasts CLKS_PER_BIT clocks. Frames stream
// back-to-back while the FIFO holds data.
//
// Ports
//   CLK       clock (UART clock domain)
//   RST       synchronous active-low reset
//   din       write handshake (DIN_DATA / DIN_VLD / DIN_RDY), slave side
//   PAR_EN    parity enable, sampled at frame start
//   PAR_TYP   parity type (0 even, 1 odd), sampled at frame start
//   TX_OUT    serial line, idles high
//   BUSY      frame in progress
//   FIFO_CNT  current FIFO occupancy
//
// Build option
//   UART_TX_FRAME_GAP_EN  when defined, GAP_BITS idle bit-times (TX_OUT high,
//                         BUSY high) follow the stop bits of every frame.
// ---------------------------------------------------------------------------
module uart_tx_frame_gen #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned CLKS_PER_BIT = 8,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned GAP_BITS     = 2
) (
   input  logic                       CLK,
   input  logic                       RST,
   uart_tx_frame_gen_if.slave         din,
   input  logic                       PAR_EN,
   input  logic                       PAR_TYP,
   output logic                       TX_OUT,
   output logic                       BUSY,
   output logic [$clog2(DEPTH+1)-1:0] FIFO_CNT
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned BCNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W  = $clog2(DATA_WIDTH);
`ifdef UART_TX_FRAME_GAP_EN
   localparam int unsigned GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
   localparam int unsigned GAP_W      = $clog2(GAP_CYCLES);
`endif

   // Elaboration-time parameter sanity checks
   if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
      $error("uart_tx_frame_gen: DATA_WIDTH must be 5..9");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_frame_gen: DEPTH must be a power of 2, at least 2");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_clks
      $error("uart_tx_frame_gen: CLKS_PER_BIT must be at least 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_frame_gen: STOP_BITS must be 1 or 2");
   end
   if (GAP_BITS < 1) begin : g_bad_gap
      $error("uart_tx_frame_gen: GAP_BITS must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
`ifdef UART_TX_FRAME_GAP_EN
      , S_GAP
`endif
   } state_t;

   // FIFO storage and bookkeeping
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_cnt;

   // Serialiser state
   state_t                r_state;
   logic [BCNT_W-1:0]     r_bit_cnt;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_stop_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_par;
   logic                  r_par_en;
   logic                  r_tx;
   logic                  r_busy;
`ifdef UART_TX_FRAME_GAP_EN
   logic [GAP_W-1:0]      r_gap_cnt;
`endif

   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_bit_end;
   logic                  w_data_last;
   logic                  w_stop_last;
   logic [DATA_WIDTH-1:0] w_head;
   logic                  w_head_par;
`ifdef UART_TX_FRAME_GAP_EN
   logic                  w_gap_end;
`endif

   assign w_full      = (r_cnt == CNT_W'(DEPTH));
   assign w_empty     = (r_cnt == '0);
   assign w_bit_end   = (r_bit_cnt == BCNT_W'(CLKS_PER_BIT - 1));
   assign w_data_last = (r_idx == IDX_W'(DATA_WIDTH - 1));
   assign w_stop_last = (r_stop_cnt == 1'(STOP_BITS - 1));
   assign w_head      = r_mem[r_rd_ptr];
   // Even parity is the XOR of the data; odd parity is its inverse.
   assign w_head_par  = (^w_head) ^ PAR_TYP;
`ifdef UART_TX_FRAME_GAP_EN
   assign w_gap_end   = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));
`endif

   // Ready is held low during reset so no write can slip into a flushing FIFO.
   assign din.DIN_RDY = RST & ~w_full;
   assign w_push      = din.DIN_VLD & din.DIN_RDY;

   // Pop the head word whenever a new frame is about to start.
   always_comb begin
      w_pop = 1'b0;
      case (r_state)
         S_IDLE:  w_pop = ~w_empty;
`ifdef UART_TX_FRAME_GAP_EN
         S_GAP:   w_pop = w_gap_end & ~w_empty;
`else
         S_STOP:  w_pop = w_bit_end & w_stop_last & ~w_empty;
`endif
         default: w_pop = 1'b0;
      endcase
   end

   // FIFO storage, written only on an accepted push
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= din.DIN_DATA;
      end
   end

   // FIFO pointers/occupancy and frame FSM
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_cnt      <= '0;
         r_state    <= S_IDLE;
         r_bit_cnt  <= '0;
         r_idx      <= '0;
         r_stop_cnt <= 1'b0;
         r_shift    <= '0;
         r_par      <= 1'b0;
         r_par_en   <= 1'b0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
`ifdef UART_TX_FRAME_GAP_EN
         r_gap_cnt  <= '0;
`endif
      end else begin
         // Pointers wrap naturally because DEPTH is a power of 2.
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_cnt <= r_cnt + 1'b1;
         end else if (!w_push && w_pop) begin
            r_cnt <= r_cnt - 1'b1;
         end

         // Frame parameters are captured with the word so that mid-frame
         // changes on PAR_EN/PAR_TYP only affect later frames.
         if (w_pop) begin
            r_shift  <= w_head;
            r_par_en <= PAR_EN;
            r_par    <= w_head_par;
         end

         case (r_state)
            S_IDLE: begin
               r_tx   <= 1'b1;
               r_busy <= 1'b0;
               if (w_pop) begin
                  r_state   <= S_START;
                  r_tx      <= 1'b0;
                  r_busy    <= 1'b1;
                  r_bit_cnt <= '0;
               end
            end

            S_START: begin
               if (w_bit_end) begin
                  r_bit_cnt <= '0;
                  r_idx     <= '0;
                  r_state   <= S_DATA;
                  r_tx      <= r_shift[0];
               end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end

            S_DATA: begin
               if (w_bit_end) begin
                  r_bit_cnt <= '0;
                  if (w_data_last) begin
                     if (r_par_en) begin
                        r_state <= S_PARITY;
                        r_tx    <= r_par;
                     end else begin
                        r_state    <= S_STOP;
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                     end
                  end else begin
                     // Next data bit is shift[1]; the shift exposes it at [0].
                     r_idx   <= r_idx + 1'b1;
                     r_shift <= r_shift >> 1;
                     r_tx    <= r_shift[1];
                  end
               end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end

            S_PARITY: begin
               if (w_bit_end) begin
                  r_bit_cnt  <= '0;
                  r_state    <= S_STOP;
                  r_tx       <= 1'b1;
                  r_stop_cnt <= 1'b0;
               end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end

            S_STOP: begin
               r_tx <= 1'b1;
               if (w_bit_end) begin
                  r_bit_cnt <= '0;
                  if (!w_stop_last) begin
                     r_stop_cnt <= r_stop_cnt + 1'b1;
                  end else begin
`ifdef UART_TX_FRAME_GAP_EN
                     r_state   <= S_GAP;
                     r_gap_cnt <= '0;
`else
                     // Zero-idle streaming: the next start bit follows directly.
                     if (w_pop) begin
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                     end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                     end
`endif
                  end
               end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end

`ifdef UART_TX_FRAME_GAP_EN
            S_GAP: begin
               r_tx <= 1'b1;
               if (w_gap_end) begin
                  r_gap_cnt <= '0;
                  if (w_pop) begin
                     r_state   <= S_START;
                     r_tx      <= 1'b0;
                     r_bit_cnt <= '0;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_gap_cnt <= r_gap_cnt + 1'b1;
               end
            end
`endif

            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign TX_OUT   = r_tx;
   assign BUSY     = r_busy;
   assign FIFO_CNT = r_cnt;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame_gen
// Scoreboard bench: accepted writes push the expected frame (data plus a
// hand-computed parity bit) into a queue; a monitor watching TX_OUT pops an
// entry at every start bit and checks each serial cycle of the frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame_gen;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CPB   = 8;
   localparam int unsigned STOPB = 1;
`ifdef UART_TX_FRAME_GAP_EN
   localparam int EXP_GAP = 16;
`else
   localparam int EXP_GAP = 0;
`endif

   logic       CLK = 1'b0;
   logic       RST;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       TX_OUT;
   logic       BUSY;
   logic [2:0] FIFO_CNT;

   uart_tx_frame_gen_if #(.DATA_WIDTH(DW)) din_if ();

   uart_tx_frame_gen #(
      .DATA_WIDTH   (DW),
      .DEPTH        (DEPTH),
      .CLKS_PER_BIT (CPB),
      .STOP_BITS    (STOPB),
      .GAP_BITS     (2)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .din      (din_if),
      .PAR_EN   (PAR_EN),
      .PAR_TYP  (PAR_TYP),
      .TX_OUT   (TX_OUT),
      .BUSY     (BUSY),
      .FIFO_CNT (FIFO_CNT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] data;
      logic       pen;
      logic       par;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   // Monitor state
   int idle_cnt    = 0;
   bit seen_frame  = 1'b0;
   bit chk_gap     = 1'b0;
   int frames_done = 0;

   // Busy-run and FIFO peak trackers
   int busy_run  = 0;
   int last_busy = 0;
   int peak      = 0;
   bit peak_clr  = 1'b0;

   initial begin
      forever begin
         @(negedge CLK);
         if (peak_clr) peak = 0;
         else if (int'(FIFO_CNT) > peak) peak = int'(FIFO_CNT);
         if (BUSY === 1'b1) begin
            busy_run++;
         end else begin
            if (busy_run != 0) last_busy = busy_run;
            busy_run = 0;
         end
      end
   end

   // Frame monitor: a low TX_OUT while idle is a start bit
   initial begin
      exp_t e;
      logic bits [16];
      int   nb;
      bit   aborted;
      forever begin
         @(negedge CLK);
         if (RST === 1'b1 && TX_OUT === 1'b0) begin
            if (chk_gap && seen_frame) chk("inter_frame_gap", 32'(idle_cnt), 32'(EXP_GAP));
            if (sb.size() == 0) begin
               chk("unexpected_frame", 32'd1, 32'd0);
               repeat (CPB * 12) @(negedge CLK);
               seen_frame = 1'b0;
            end else begin
               e  = sb.pop_front();
               nb = 1 + int'(DW) + int'(e.pen) + int'(STOPB);
               bits[0] = 1'b0;
               for (int i = 0; i < int'(DW); i++) bits[1+i] = e.data[i];
               if (e.pen) bits[1+DW] = e.par;
               for (int i = nb - int'(STOPB); i < nb; i++) bits[i] = 1'b1;
               aborted = 1'b0;
               for (int b = 0; b < nb && !aborted; b++) begin
                  for (int c = 0; c < int'(CPB) && !aborted; c++) begin
                     if (!(b == 0 && c == 0)) @(negedge CLK);
                     if (RST !== 1'b1) begin
                        aborted = 1'b1;
                     end else begin
                        chk($sformatf("f%0d_d%02h_bit%0d_cyc%0d", frames_done, e.data, b, c),
                            32'(TX_OUT), 32'(bits[b]));
                        if (c == 0) chk($sformatf("f%0d_busy_bit%0d", frames_done, b),
                                        32'(BUSY), 32'd1);
                     end
                  end
               end
               frames_done++;
               seen_frame = !aborted;
               idle_cnt   = 0;
            end
         end else if (RST === 1'b1) begin
            idle_cnt++;
         end else begin
            idle_cnt   = 0;
            seen_frame = 1'b0;
         end
      end
   end

   // Hold DIN_VLD until accepted; returns #1 after the accepting edge.
   task automatic write_word(input logic [7:0] d, input logic pen, input logic par);
      exp_t e;
      logic acc;
      int   t;
      din_if.DIN_DATA = d;
      din_if.DIN_VLD  = 1'b1;
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 2000) begin
         acc = din_if.DIN_RDY;
         @(posedge CLK);
         #1;
         t++;
      end
      din_if.DIN_VLD = 1'b0;
      if (acc) begin
         e.data = d; e.pen = pen; e.par = par;
         sb.push_back(e);
      end else begin
         chk("write_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while ((BUSY !== 1'b0 || FIFO_CNT !== 3'd0) && t < 5000) begin
         @(posedge CLK);
         #1;
         t++;
      end
      if (t >= 5000) chk({name, "_idle_timeout"}, 32'd0, 32'd1);
      repeat (3) @(posedge CLK);
      #1;
      chk({name, "_sb_drained"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      logic [7:0] v4 [6];
      logic       exp_acc [6];
      logic       acc;
      int         t;
      int         f0;
      exp_t       e;

      v4      = '{8'h0A, 8'h0F, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      exp_acc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      RST             = 1'b0;
      PAR_EN          = 1'b0;
      PAR_TYP         = 1'b0;
      din_if.DIN_DATA = '0;
      din_if.DIN_VLD  = 1'b0;

      // Reset state
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_tx_out",   32'(TX_OUT),        32'd1);
      chk("rst_busy",     32'(BUSY),          32'd0);
      chk("rst_fifo_cnt", 32'(FIFO_CNT),      32'd0);
      chk("rst_din_rdy",  32'(din_if.DIN_RDY), 32'd0);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      chk("rdy_after_rst", 32'(din_if.DIN_RDY), 32'd1);

      // 1: 0xAA, even parity -> parity 0, first-bit latency of one edge
      PAR_EN = 1'b1; PAR_TYP = 1'b0;
      write_word(8'hAA, 1'b1, 1'b0);
      chk("t1_tx_at_accept", 32'(TX_OUT), 32'd1);
      chk("t1_cnt_at_accept", 32'(FIFO_CNT), 32'd1);
      @(posedge CLK);
      #1;
      chk("t1_start_latency", 32'(TX_OUT), 32'd0);
      chk("t1_busy_rise",     32'(BUSY),   32'd1);
      wait_idle("t1");
      chk("t1_busy_len", 32'(last_busy), 32'(88 + EXP_GAP));

      // 2: 0x08 odd -> parity 0; mid-frame PAR changes ignored; then even -> 1
      PAR_EN = 1'b1; PAR_TYP = 1'b1;
      write_word(8'h08, 1'b1, 1'b0);
      repeat (20) @(posedge CLK);
      #1;
      PAR_EN = 1'b0; PAR_TYP = 1'b0;
      repeat (20) @(posedge CLK);
      #1;
      PAR_EN = 1'b1;
      wait_idle("t2a");
      write_word(8'h08, 1'b1, 1'b1);
      wait_idle("t2b");

      // 3: parity off -> 80-cycle frame
      PAR_EN = 1'b0;
      write_word(8'h0F, 1'b0, 1'b0);
      wait_idle("t3");
      chk("t3_busy_len", 32'(last_busy), 32'(80 + EXP_GAP));

      // 4: six writes on consecutive cycles, odd parity (all six words -> 1)
      PAR_EN = 1'b1; PAR_TYP = 1'b1;
      peak_clr = 1'b1;
      @(posedge CLK);
      #1;
      peak_clr = 1'b0;
      f0 = frames_done;
      t  = 0;
      for (int i = 0; i < 6; i++) begin
         din_if.DIN_DATA = v4[i];
         din_if.DIN_VLD  = 1'b1;
         acc = din_if.DIN_RDY;
         @(posedge CLK);
         #1;
         if (i > 0) t++;
         chk($sformatf("t4_accept%0d", i), 32'(acc), 32'(exp_acc[i]));
         if (acc) begin
            e.data = v4[i]; e.pen = 1'b1; e.par = 1'b1;
            sb.push_back(e);
         end
      end
      chk("t4_fifo_full", 32'(FIFO_CNT), 32'd4);
      chk_gap = 1'b1;
      acc = 1'b0;
      while (!acc && t < 2000) begin
         acc = din_if.DIN_RDY;
         @(posedge CLK);
         #1;
         t++;
      end
      din_if.DIN_VLD = 1'b0;
      chk("t4_sixth_accept_edge", 32'(t), 32'(90 + EXP_GAP));
      if (acc) begin
         e.data = v4[5]; e.pen = 1'b1; e.par = 1'b1;
         sb.push_back(e);
      end
      wait_idle("t4");
      chk_gap = 1'b0;
      chk("t4_peak_cnt",   32'(peak),             32'd4);
      chk("t4_frame_count", 32'(frames_done - f0), 32'd6);

      // 5: reset during the data bits flushes FIFO and frame
      PAR_EN = 1'b1; PAR_TYP = 1'b0;
      write_word(8'h55, 1'b1, 1'b0);
      write_word(8'h33, 1'b1, 1'b0);
      repeat (30) @(posedge CLK);
      #1;
      RST = 1'b0;
      @(posedge CLK);
      #1;
      chk("t5_tx_out",   32'(TX_OUT),         32'd1);
      chk("t5_busy",     32'(BUSY),           32'd0);
      chk("t5_fifo_cnt", 32'(FIFO_CNT),       32'd0);
      chk("t5_din_rdy",  32'(din_if.DIN_RDY), 32'd0);
      sb.delete();
      RST = 1'b1;
      repeat (200) @(posedge CLK);
      #1;
      chk("t5_quiet_busy", 32'(BUSY),     32'd0);
      chk("t5_quiet_tx",   32'(TX_OUT),   32'd1);
      chk("t5_quiet_cnt",  32'(FIFO_CNT), 32'd0);
      // Recovery: 0xC3 has four ones, odd parity -> 1
      PAR_TYP = 1'b1;
      write_word(8'hC3, 1'b1, 1'b1);
      wait_idle("t5r");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
